elastic_config_loader: RTL and testbench
========================================

ELASTIC_CONFIG_LOADER -- requirements
Module: elastic_config_loader

Interface
REQ-001 Parameter PE_NUM, default 16, number of PEs served.
REQ-002 Parameter PE_ID_BIT_LENGTH, default 4, width of PE identifier.
REQ-003 Parameters DATA_WIDTH, CONTEXT_SIZE, CONTEXT_SIZE_BIT_LENGTH, INPUT_NUM_BIT_LENGTH, OPERATION_BIT_LENGTH and NEIGHBOR_PE_NUM SHALL come from the shared package.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 load_start  input  1  one-cycle request to begin a configuration load.
REQ-007 cfg_valid / cfg_ready  input / output  1 / 1  config-word stream handshake.
REQ-008 cfg_last  input  1  marks the final word of a load.
REQ-009 cfg_pe_id / cfg_context_id  input  PE_ID_BIT_LENGTH / CONTEXT_SIZE_BIT_LENGTH  target PE and context slot.
REQ-010 cfg_input_index_1, cfg_input_index_2, cfg_output_mask, cfg_op, cfg_const  input  INPUT_NUM_BIT_LENGTH x2, NEIGHBOR_PE_NUM, OPERATION_BIT_LENGTH, DATA_WIDTH  config payload.
REQ-011 config_input_PE_index_1/2, config_output_PE_index, config_op, config_const_data, config_index  output  same widths  payload broadcast to every PE.
REQ-012 write_config_data  output  PE_NUM  one-hot per-PE write strobe.
REQ-013 mapping_context_max_id  output  CONTEXT_SIZE_BIT_LENGTH  highest context id loaded.
REQ-014 start_exec  output  1  one-cycle execution start pulse to all PEs.
REQ-015 busy / error  output  1 / 1  load in progress / sticky invalid-word flag.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, START.
REQ-017 IDLE: cfg_ready=0; load_start=1 -> LOAD, clears error, clears max-id register to 0.
REQ-018 LOAD: cfg_ready=1, busy=1; word accepted when cfg_valid&&cfg_ready.
REQ-019 Accepted valid word SHALL register payload onto config_* outputs and assert write_config_data[cfg_pe_id] for exactly one cycle, one cycle after acceptance (latency 1).
REQ-020 write_config_data SHALL be all-zero in every cycle without a registered write.
REQ-021 Word is invalid when cfg_pe_id >= PE_NUM or cfg_context_id >= CONTEXT_SIZE; invalid word SHALL be consumed, produce no strobe, and set error until next load_start.
REQ-022 Valid word SHALL update max-id := max(max-id, cfg_context_id); mapping_context_max_id SHALL show this register continuously.
REQ-023 Accepted word with cfg_last=1 (valid or invalid) -> START.
REQ-024 START: busy=1, cfg_ready=0; start_exec=1 for one cycle, which SHALL be the cycle after the last write strobe; next state IDLE.
REQ-025 Back-to-back words SHALL be accepted every cycle with no bubble.
REQ-026 load_start in LOAD or START SHALL be ignored.
REQ-027 Same (pe, context) written twice: later word wins; no error.
REQ-028 Load whose only word is invalid with cfg_last SHALL still pulse start_exec with max-id 0.

Reset
REQ-029 On reset_n=0: state IDLE; cfg_ready, write_config_data, start_exec, busy, error, max-id and all config_* outputs 0, immediately (asynchronous).
REQ-030 Reset mid-LOAD SHALL abandon the load with no start_exec; pending strobe SHALL be suppressed.

Structure
REQ-031 FSM state enum and PE_NUM/PE_ID_BIT_LENGTH defaults SHALL live in the shared parameter package alongside the existing CGRA constants.
REQ-032 Single module; no sub-module; PE-id one-hot decode inline.

Verification
REQ-033 Load 3 words (PE2 ctx0, PE2 ctx1, PE5 ctx2 last) back-to-back -> strobes 0x0004, 0x0004, 0x0020 on consecutive cycles, max_id=2, start_exec one cycle after third strobe.
REQ-034 Word with cfg_pe_id=PE_NUM mid-load -> no strobe that cycle, error=1 persists through START and IDLE, cleared by next load_start.
REQ-035 cfg_valid toggling 1,0,1,0 with cfg_last on second word -> two strobes separated by one idle cycle, single start_exec.
REQ-036 Assert reset_n=0 after first of 3 words -> outputs zero immediately, no start_exec, FSM IDLE.
REQ-037 load_start pulsed during LOAD -> ignored; max-id not cleared.
REQ-038 Context ids 3, 1 -> mapping_context_max_id stays 3.

Source files
------------

// File: rtl/elastic_config_loader_pkg.sv
// -----------------------------------------------------------------------------
// elastic_config_loader_pkg
//   Shared CGRA parameter package. It holds:
//     - the CGRA datapath/context constants used across the array,
//     - the default PE count and PE identifier width for the config loader,
//     - the config loader FSM state encoding.
// -----------------------------------------------------------------------------
package elastic_config_loader_pkg;

  // CGRA datapath and context constants
  localparam int DATA_WIDTH              = 16;
  localparam int CONTEXT_SIZE            = 6;  // context slots per PE
  localparam int CONTEXT_SIZE_BIT_LENGTH = 3;  // wide enough for ids 0..7
  localparam int INPUT_NUM_BIT_LENGTH    = 3;
  localparam int OPERATION_BIT_LENGTH    = 4;
  localparam int NEIGHBOR_PE_NUM         = 4;

  // Config loader defaults
  localparam int PE_NUM_DEFAULT           = 16;
  localparam int PE_ID_BIT_LENGTH_DEFAULT = 4;

  // Config loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2
  } ecl_state_e;

endpackage

// File: rtl/elastic_config_loader.sv
// -----------------------------------------------------------------------------
// elastic_config_loader
//   Accepts a stream of configuration words and broadcasts each valid word to
//   all PEs, with a one-hot write strobe selecting the target PE. After the word
//   marked cfg_last is accepted, execution is started with a one-cycle pulse.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   load_start                   begins a load (only honoured while idle)
//   cfg_valid / cfg_ready        config word handshake
//   cfg_last                     final word of the load
//   cfg_pe_id, cfg_context_id    target PE and context slot
//   cfg_input_index_1/2, cfg_output_mask, cfg_op, cfg_const   payload
//   config_*                     registered payload broadcast to every PE
//   write_config_data            one-hot per-PE write strobe (one cycle)
//   mapping_context_max_id       highest context id written in this load
//   start_exec                   one-cycle execution start pulse
//   busy                         load in progress
//   error                        sticky flag: an invalid word was consumed
// -----------------------------------------------------------------------------
module elastic_config_loader
  import elastic_config_loader_pkg::*;
#(
  parameter int PE_NUM           = PE_NUM_DEFAULT,
  parameter int PE_ID_BIT_LENGTH = PE_ID_BIT_LENGTH_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               load_start,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic                               cfg_last,
  input  logic [PE_ID_BIT_LENGTH-1:0]        cfg_pe_id,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_context_id,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_1,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_2,
  input  logic [NEIGHBOR_PE_NUM-1:0]         cfg_output_mask,
  input  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op,
  input  logic [DATA_WIDTH-1:0]              cfg_const,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic [PE_NUM-1:0]                  write_config_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               start_exec,
  output logic                               busy,
  output logic                               error
);

  ecl_state_e                         state_q, state_d;
  logic                               cfg_ready_q, cfg_ready_d;
  logic                               busy_q, busy_d;
  logic                               error_q, error_d;
  logic                               start_exec_q, start_exec_d;
  logic [PE_NUM-1:0]                  wr_q, wr_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q, max_id_d;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    in_idx_1_q, in_idx_1_d;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    in_idx_2_q, in_idx_2_d;
  logic [NEIGHBOR_PE_NUM-1:0]         out_mask_q, out_mask_d;
  logic [OPERATION_BIT_LENGTH-1:0]    op_q, op_d;
  logic [DATA_WIDTH-1:0]              const_q, const_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx_q, ctx_d;

  logic accept;
  logic word_ok;

  // cfg_ready_q mirrors "state is LOAD", so this is the handshake itself.
  assign accept  = cfg_valid && cfg_ready_q;
  assign word_ok = (int'(cfg_pe_id) < PE_NUM) && (int'(cfg_context_id) < CONTEXT_SIZE);

  always_comb begin
    state_d      = state_q;
    error_d      = error_q;
    max_id_d     = max_id_q;
    start_exec_d = 1'b0;
    wr_d         = '0;
    in_idx_1_d   = in_idx_1_q;
    in_idx_2_d   = in_idx_2_q;
    out_mask_d   = out_mask_q;
    op_d         = op_q;
    const_d      = const_q;
    ctx_d        = ctx_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          error_d  = 1'b0;
          max_id_d = '0;
        end
      end

      ST_LOAD: begin
        if (accept) begin
          if (word_ok) begin
            // Inline one-hot decode of the target PE.
            for (int i = 0; i < PE_NUM; i++) begin
              wr_d[i] = (int'(cfg_pe_id) == i);
            end
            in_idx_1_d = cfg_input_index_1;
            in_idx_2_d = cfg_input_index_2;
            out_mask_d = cfg_output_mask;
            op_d       = cfg_op;
            const_d    = cfg_const;
            ctx_d      = cfg_context_id;
            if (cfg_context_id > max_id_q) begin
              max_id_d = cfg_context_id;
            end
          end else begin
            error_d = 1'b1;
          end
          if (cfg_last) begin
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        // START spans the cycle of the final strobe; the pulse registered
        // here therefore lands in the following cycle.
        start_exec_d = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cfg_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cfg_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
      start_exec_q <= 1'b0;
      wr_q         <= '0;
      max_id_q     <= '0;
      in_idx_1_q   <= '0;
      in_idx_2_q   <= '0;
      out_mask_q   <= '0;
      op_q         <= '0;
      const_q      <= '0;
      ctx_q        <= '0;
    end else begin
      state_q      <= state_d;
      cfg_ready_q  <= cfg_ready_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
      start_exec_q <= start_exec_d;
      wr_q         <= wr_d;
      max_id_q     <= max_id_d;
      in_idx_1_q   <= in_idx_1_d;
      in_idx_2_q   <= in_idx_2_d;
      out_mask_q   <= out_mask_d;
      op_q         <= op_d;
      const_q      <= const_d;
      ctx_q        <= ctx_d;
    end
  end

  assign cfg_ready               = cfg_ready_q;
  assign busy                    = busy_q;
  assign error                   = error_q;
  assign start_exec              = start_exec_q;
  assign write_config_data       = wr_q;
  assign mapping_context_max_id  = max_id_q;
  assign config_input_PE_index_1 = in_idx_1_q;
  assign config_input_PE_index_2 = in_idx_2_q;
  assign config_output_PE_index  = out_mask_q;
  assign config_op               = op_q;
  assign config_const_data       = const_q;
  assign config_index            = ctx_q;

endmodule

// File: tb/tb_elastic_config_loader.sv
// -----------------------------------------------------------------------------
// tb_elastic_config_loader
//   Directed bench for elastic_config_loader with PE_NUM=12 so that an
//   out-of-range PE id (12) fits in the 4-bit id field.
// -----------------------------------------------------------------------------
module tb_elastic_config_loader;
  import elastic_config_loader_pkg::*;

  localparam int PN = 12;
  localparam int PB = 4;

  logic                               clk;
  logic                               reset_n;
  logic                               load_start;
  logic                               cfg_valid;
  logic                               cfg_ready;
  logic                               cfg_last;
  logic [PB-1:0]                      cfg_pe_id;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_context_id;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_1;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_index_2;
  logic [NEIGHBOR_PE_NUM-1:0]         cfg_output_mask;
  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op;
  logic [DATA_WIDTH-1:0]              cfg_const;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1;
  logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2;
  logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index;
  logic [OPERATION_BIT_LENGTH-1:0]    config_op;
  logic [DATA_WIDTH-1:0]              config_const_data;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index;
  logic [PN-1:0]                      write_config_data;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id;
  logic                               start_exec;
  logic                               busy;
  logic                               error;

  int total = 0;
  int bad   = 0;

  elastic_config_loader #(.PE_NUM(PN), .PE_ID_BIT_LENGTH(PB)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .load_start              (load_start),
    .cfg_valid               (cfg_valid),
    .cfg_ready               (cfg_ready),
    .cfg_last                (cfg_last),
    .cfg_pe_id               (cfg_pe_id),
    .cfg_context_id          (cfg_context_id),
    .cfg_input_index_1       (cfg_input_index_1),
    .cfg_input_index_2       (cfg_input_index_2),
    .cfg_output_mask         (cfg_output_mask),
    .cfg_op                  (cfg_op),
    .cfg_const               (cfg_const),
    .config_input_PE_index_1 (config_input_PE_index_1),
    .config_input_PE_index_2 (config_input_PE_index_2),
    .config_output_PE_index  (config_output_PE_index),
    .config_op               (config_op),
    .config_const_data       (config_const_data),
    .config_index            (config_index),
    .write_config_data       (write_config_data),
    .mapping_context_max_id  (mapping_context_max_id),
    .start_exec              (start_exec),
    .busy                    (busy),
    .error                   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic last, input logic [3:0] pe, input logic [2:0] ctx,
                      input logic [3:0] op, input logic [15:0] cst);
    cfg_valid         = 1'b1;
    cfg_last          = last;
    cfg_pe_id         = pe;
    cfg_context_id    = ctx;
    cfg_op            = op;
    cfg_const         = cst;
    cfg_input_index_1 = 3'd1;
    cfg_input_index_2 = 3'd2;
    cfg_output_mask   = 4'b1010;
  endtask

  task automatic idle_in();
    cfg_valid  = 1'b0;
    cfg_last   = 1'b0;
    load_start = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    load_start = 1'b0;
    word(1'b0, 4'd0, 3'd0, 4'd0, 16'd0);
    cfg_valid  = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_wr", 32'(write_config_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start_exec), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_ready", 32'(cfg_ready), 32'd0);

    // ---- three back-to-back words ----
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("l1_ready", 32'(cfg_ready), 32'd1);
    chk("l1_busy", 32'(busy), 32'd1);
    chk("l1_wr_none", 32'(write_config_data), 32'd0);
    word(1'b0, 4'd2, 3'd0, 4'h3, 16'h1111);
    tick();
    chk("l1_w0_wr", 32'(write_config_data), 32'h004);
    chk("l1_w0_idx", 32'(config_index), 32'd0);
    word(1'b0, 4'd2, 3'd1, 4'h4, 16'h2222);
    tick();
    chk("l1_w1_wr", 32'(write_config_data), 32'h004);
    chk("l1_w1_idx", 32'(config_index), 32'd1);
    chk("l1_w1_max", 32'(mapping_context_max_id), 32'd1);
    word(1'b1, 4'd5, 3'd2, 4'h9, 16'hBEEF);
    tick();
    idle_in();
    chk("l1_w2_wr", 32'(write_config_data), 32'h020);
    chk("l1_w2_const", 32'(config_const_data), 32'hBEEF);
    chk("l1_w2_op", 32'(config_op), 32'h9);
    chk("l1_w2_mask", 32'(config_output_PE_index), 32'hA);
    chk("l1_w2_in1", 32'(config_input_PE_index_1), 32'd1);
    chk("l1_w2_in2", 32'(config_input_PE_index_2), 32'd2);
    chk("l1_max", 32'(mapping_context_max_id), 32'd2);
    chk("l1_start_early", 32'(start_exec), 32'd0);
    chk("l1_ready_start", 32'(cfg_ready), 32'd0);
    chk("l1_busy_start", 32'(busy), 32'd1);
    tick();
    chk("l1_start", 32'(start_exec), 32'd1);
    chk("l1_wr_after", 32'(write_config_data), 32'd0);
    tick();
    chk("l1_start_once", 32'(start_exec), 32'd0);
    chk("l1_idle_busy", 32'(busy), 32'd0);

    // ---- invalid PE id mid-load, max-id tracking, rewrite ----
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("l2_max_clr", 32'(mapping_context_max_id), 32'd0);
    word(1'b0, 4'd3, 3'd3, 4'h1, 16'h0003);
    tick();
    chk("l2_w0_wr", 32'(write_config_data), 32'h008);
    chk("l2_w0_max", 32'(mapping_context_max_id), 32'd3);
    word(1'b0, 4'd12, 3'd1, 4'h1, 16'h0004);
    tick();
    chk("l2_bad_wr", 32'(write_config_data), 32'd0);
    chk("l2_bad_err", 32'(error), 32'd1);
    chk("l2_bad_ready", 32'(cfg_ready), 32'd1);
    word(1'b0, 4'd3, 3'd1, 4'h1, 16'h0005);
    tick();
    chk("l2_ctx1_wr", 32'(write_config_data), 32'h008);
    chk("l2_max_hold", 32'(mapping_context_max_id), 32'd3);
    word(1'b1, 4'd3, 3'd3, 4'h2, 16'h0006);
    tick();
    idle_in();
    chk("l2_rewrite_wr", 32'(write_config_data), 32'h008);
    chk("l2_rewrite_const", 32'(config_const_data), 32'h0006);
    chk("l2_err_start", 32'(error), 32'd1);
    tick();
    chk("l2_start", 32'(start_exec), 32'd1);
    chk("l2_err_idle", 32'(error), 32'd1);
    tick();
    chk("l2_err_idle2", 32'(error), 32'd1);

    // ---- toggling valid, load_start ignored during LOAD ----
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("l3_err_clr", 32'(error), 32'd0);
    word(1'b0, 4'd1, 3'd4, 4'h1, 16'h0007);
    tick();
    chk("l3_w0_wr", 32'(write_config_data), 32'h002);
    chk("l3_w0_max", 32'(mapping_context_max_id), 32'd4);
    cfg_valid  = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("l3_gap_wr", 32'(write_config_data), 32'd0);
    chk("l3_ls_ignored_max", 32'(mapping_context_max_id), 32'd4);
    chk("l3_ls_ignored_ready", 32'(cfg_ready), 32'd1);
    word(1'b1, 4'd0, 3'd2, 4'h1, 16'h0008);
    tick();
    idle_in();
    chk("l3_w1_wr", 32'(write_config_data), 32'h001);
    chk("l3_w1_max", 32'(mapping_context_max_id), 32'd4);
    tick();
    chk("l3_start", 32'(start_exec), 32'd1);
    tick();
    chk("l3_start_once", 32'(start_exec), 32'd0);

    // ---- single invalid (context out of range) last word ----
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    word(1'b1, 4'd0, 3'd6, 4'h1, 16'h0009);
    tick();
    idle_in();
    chk("l4_wr", 32'(write_config_data), 32'd0);
    chk("l4_err", 32'(error), 32'd1);
    chk("l4_ready", 32'(cfg_ready), 32'd0);
    tick();
    chk("l4_start", 32'(start_exec), 32'd1);
    chk("l4_max", 32'(mapping_context_max_id), 32'd0);
    tick();

    // ---- asynchronous reset mid-load ----
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    word(1'b0, 4'd7, 3'd5, 4'hF, 16'hCAFE);
    tick();
    chk("l5_w0_wr", 32'(write_config_data), 32'h080);
    chk("l5_w0_max", 32'(mapping_context_max_id), 32'd5);
    word(1'b0, 4'd8, 3'd1, 4'hE, 16'h1234);
    #2;
    reset_n = 1'b0;
    #1;
    chk("l5_rst_wr", 32'(write_config_data), 32'd0);
    chk("l5_rst_max", 32'(mapping_context_max_id), 32'd0);
    chk("l5_rst_busy", 32'(busy), 32'd0);
    chk("l5_rst_ready", 32'(cfg_ready), 32'd0);
    chk("l5_rst_const", 32'(config_const_data), 32'd0);
    chk("l5_rst_op", 32'(config_op), 32'd0);
    chk("l5_rst_err", 32'(error), 32'd0);
    tick();
    chk("l5_rst_hold_wr", 32'(write_config_data), 32'd0);
    chk("l5_rst_hold_start", 32'(start_exec), 32'd0);
    reset_n = 1'b1;
    idle_in();
    tick();
    chk("l5_post_ready", 32'(cfg_ready), 32'd0);
    chk("l5_post_start", 32'(start_exec), 32'd0);
    chk("l5_post_busy", 32'(busy), 32'd0);
    tick();
    chk("l5_post_start2", 32'(start_exec), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Per-transaction log: one line per accepted config word.
  always @(posedge clk) begin
    if (reset_n && cfg_valid && cfg_ready) begin
      $display("[%0t] word pe=%0d ctx=%0d last=%0d", $time, cfg_pe_id, cfg_context_id, cfg_last);
    end
  end

endmodule
